// File: rtl/operand_serializer.sv
// rtl/operand_serializer.sv - serializes an operand pair one bit per clock, then drains the downstream stage and pulses done
// Optional feature macro MSB_FIRST_EN: present the MSB first (left shift) instead of the LSB first.
module operand_serializer #(
    parameter int WIDTH    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           op_a,
    input  logic [WIDTH-1:0]           op_b,
    output logic                       a_bit,
    output logic                       b_bit,
    output logic                       bit_valid,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic                       bit_last,
    output logic                       busy,
    output logic                       done
);
    localparam int IW = $clog2(WIDTH);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [IW-1:0] LAST_CNT  = IW'(WIDTH - 1);
    // Wraps to all-ones when PIPE_LAT is 0; DRAIN is never entered in that build.
    localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT - 1);

`ifdef MSB_FIRST_EN
    localparam int OUT_POS = WIDTH - 1;
`else
    localparam int OUT_POS = 0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_sh_a;
    logic [WIDTH-1:0]  r_sh_b;
    logic [IW-1:0]     r_cnt;
    logic [DW-1:0]     r_dcnt;
    logic [WIDTH-1:0]  w_sh_a_nxt;
    logic [WIDTH-1:0]  w_sh_b_nxt;
    logic              w_cnt_last;

`ifdef MSB_FIRST_EN
    assign w_sh_a_nxt = {r_sh_a[WIDTH-2:0], 1'b0};
    assign w_sh_b_nxt = {r_sh_b[WIDTH-2:0], 1'b0};
`else
    assign w_sh_a_nxt = {1'b0, r_sh_a[WIDTH-1:1]};
    assign w_sh_b_nxt = {1'b0, r_sh_b[WIDTH-1:1]};
`endif

    assign w_cnt_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        bit_idx   = '0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bit_valid = 1'b1;
                a_bit     = r_sh_a[OUT_POS];
                b_bit     = r_sh_b[OUT_POS];
                bit_last  = w_cnt_last;
`ifdef MSB_FIRST_EN
                bit_idx   = LAST_CNT - r_cnt;
`else
                bit_idx   = r_cnt;
`endif
                if (w_cnt_last) begin
                    w_next = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DRAIN_END) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
            r_cnt  <= '0;
            r_dcnt <= '0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_sh_a <= op_a;
                r_sh_b <= op_b;
                r_cnt  <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sh_a <= w_sh_a_nxt;
                r_sh_b <= w_sh_b_nxt;
                r_cnt  <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end
            r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 1'b1 : '0;
        end
    end
endmodule
